datamemory_mp: RTL

//  N-port shared data memory for the matrix-multiply datapath; generalises the fixed 4-port, 16x256 store.

---
 rtl/dm_pkg.sv | 16 +
 rtl/dm_clear_fsm.sv | 59 +++++
 rtl/dm_rd_lane.sv | 45 ++++
 rtl/datamemory_mp.sv | 84 ++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the multi-port data memory: clear FSM encoding and read latency bounds.
package dm_pkg;

  typedef enum logic {
    DM_IDLE  = 1'b0,
    DM_CLEAR = 1'b1
  } dm_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/dm_clear_fsm.sv
// Zero-fill sequencer: sweeps every address once, holding ports off while it runs.
module dm_clear_fsm
  import dm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  dm_state_e         state, state_nxt;
  logic [ADDR_W-1:0] caddr, caddr_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DM_IDLE;
      caddr <= '0;
    end else begin
      state <= state_nxt;
      caddr <= caddr_nxt;
    end
  end

  // clear_start during a sweep is ignored; the counter parks at 0 on exit
  always_comb begin
    state_nxt  = state;
    caddr_nxt  = caddr;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    ready      = 1'b1;
    case (state)
      DM_IDLE: begin
        if (clear_start) state_nxt = DM_CLEAR;
      end
      DM_CLEAR: begin
        clear_busy = 1'b1;
        ready      = 1'b0;
        if (caddr == {ADDR_W{1'b1}}) begin
          clear_done = 1'b1;
          state_nxt  = DM_IDLE;
          caddr_nxt  = '0;
        end else begin
          caddr_nxt = caddr + 1'b1;
        end
      end
      default: state_nxt = DM_IDLE;
    endcase
  end

  assign clr_we   = clear_busy;
  assign clr_addr = caddr;

endmodule

// File: rtl/dm_rd_lane.sv
// One port's read return path: valid shift register plus held read-data register.
module dm_rd_lane
  import dm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [RD_LAT:0]   vld_pipe;
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] stage_dat;

  assign vld_pipe = {vld_q, rd_en};
  assign rvalid   = vld_pipe[RD_LAT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_pipe[RD_LAT-1:0];
  end

  // Extra stage captures the array word at the accepting edge (read-first)
  if (RD_LAT == RD_LAT_MAX) begin : g_lat2
    logic [DATA_W-1:0] dat1;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) dat1 <= '0;
      else       dat1 <= rd_word;
    end
    assign stage_dat = dat1;
  end else begin : g_lat1
    assign stage_dat = rd_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     rdata <= '0;
    else if (vld_pipe[RD_LAT-1])   rdata <= stage_dat;
  end

endmodule

// File: rtl/datamemory_mp.sv
// N-port shared data memory with lowest-port-wins write arbitration and a built-in clear engine.
module datamemory_mp
  import dm_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic                          ready,
  output logic [NUM_PORTS-1:0]          wr_collide,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] a;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_q;
  logic [NUM_PORTS-1:0]             acc, rd_en, wr_acc, win;
  logic                             clr_we;
  logic [ADDR_W-1:0]                clr_addr;
  logic [DATA_W-1:0]                mem [DEPTH];

  assign a      = addr;
  assign w      = wdata;
  assign rdata  = rd_q;
  assign acc    = req & {NUM_PORTS{ready}};
  assign rd_en  = acc & ~we;
  assign wr_acc = acc & we;

  dm_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clock       (clock),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ready       (ready),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr)
  );

  // A write survives only if no lower-indexed port writes the same address
  always_comb begin
    win = wr_acc;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int q = 0; q < NUM_PORTS; q++)
        if (q < p && wr_acc[q] && wr_acc[p] && a[q] == a[p]) win[p] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_collide <= '0;
    else       wr_collide <= wr_acc & ~win;
  end

  // Array is not reset; clear and port writes never overlap since ready is low while clearing
  always_ff @(posedge clock) begin
    if (clr_we) mem[clr_addr] <= '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (win[p]) mem[a[p]] <= w[p];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    dm_rd_lane #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_lane (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (rd_en[p]),
      .rd_word (mem[a[p]]),
      .rdata   (rd_q[p]),
      .rvalid  (rvalid[p])
    );
  end

endmodule
